// File: rtl/csr_access_ctrl_if.sv
// Bundles the two requester ports, the response port and the CSR file port
// of the CSR access controller.
interface csr_access_ctrl_if;
  // pipeline requester
  logic        p_req_valid_i;
  logic        p_req_ready_o;
  logic [1:0]  p_req_op_i;
  logic [11:0] p_req_addr_i;
  logic [31:0] p_req_wdata_i;
  // debug requester
  logic        d_req_valid_i;
  logic        d_req_ready_o;
  logic [1:0]  d_req_op_i;
  logic [11:0] d_req_addr_i;
  logic [31:0] d_req_wdata_i;
  // response
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_src_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  // CSR file
  logic [11:0] csr_rs_o;
  logic [31:0] csr_rdata_i;
  logic [11:0] csr_rd_o;
  logic [31:0] csr_wdata_o;
  logic        csr_we_o;

  // controller side
  modport slave (
    input  p_req_valid_i, p_req_op_i, p_req_addr_i, p_req_wdata_i,
    input  d_req_valid_i, d_req_op_i, d_req_addr_i, d_req_wdata_i,
    input  rsp_ready_i, csr_rdata_i,
    output p_req_ready_o, d_req_ready_o,
    output rsp_valid_o, rsp_src_o, rsp_rdata_o, rsp_err_o,
    output csr_rs_o, csr_rd_o, csr_wdata_o, csr_we_o
  );

  // requester / CSR-file side
  modport master (
    output p_req_valid_i, p_req_op_i, p_req_addr_i, p_req_wdata_i,
    output d_req_valid_i, d_req_op_i, d_req_addr_i, d_req_wdata_i,
    output rsp_ready_i, csr_rdata_i,
    input  p_req_ready_o, d_req_ready_o,
    input  rsp_valid_o, rsp_src_o, rsp_rdata_o, rsp_err_o,
    input  csr_rs_o, csr_rd_o, csr_wdata_o, csr_we_o
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access controller: arbitrates pipeline and debug requests, performs a
// read-modify-write on the CSR file (READ/RW/RS/RC) and returns the old value.
module csr_access_ctrl #(
  parameter bit FAIR_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  csr_access_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef struct packed {
    logic        src;    // 0 pipeline, 1 debug
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] old_q;
  logic        last_grant_q;   // 1 = debug was granted last
  logic        gnt_p, gnt_d, accept;
  logic        wants_write, ro_addr, do_write, ro_err;
  logic [31:0] new_val;

  // Grant only in IDLE and never while reset is held; pipeline wins ties
  // unless fairness is on and it was the last one served.
  always_comb begin
    gnt_p = 1'b0;
    gnt_d = 1'b0;
    if (reset_ni && state_q == IDLE) begin
      if (bus.p_req_valid_i && (!bus.d_req_valid_i || !FAIR_EN || last_grant_q))
        gnt_p = 1'b1;
      else if (bus.d_req_valid_i)
        gnt_d = 1'b1;
    end
  end

  assign accept = gnt_p | gnt_d;

  // Write decision and new value, all from the latched request and old value.
  always_comb begin
    ro_addr     = (req_q.addr[11:10] == 2'b11);
    wants_write = (req_q.op == OP_RW) ||
                  ((req_q.op == OP_RS || req_q.op == OP_RC) && req_q.wdata != '0);
    do_write    = wants_write && !ro_addr;
    ro_err      = wants_write && ro_addr;
    unique case (req_q.op)
      OP_RW:   new_val = req_q.wdata;
      OP_RS:   new_val = old_q | req_q.wdata;
      OP_RC:   new_val = old_q & ~req_q.wdata;
      default: new_val = old_q;
    endcase
  end

  // State register, grant history, request latch and old-value capture.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      old_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt_d;
        req_q <= gnt_d ? req_t'{1'b1, bus.d_req_op_i, bus.d_req_addr_i, bus.d_req_wdata_i}
                       : req_t'{1'b0, bus.p_req_op_i, bus.p_req_addr_i, bus.p_req_wdata_i};
      end
      if (state_q == READ)
        old_q <= bus.csr_rdata_i;
    end
  end

  // Next-state: fixed READ->WRITE->RESP walk, leave RESP on handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is zero outside the state that owns it.
  always_comb begin
    bus.p_req_ready_o = gnt_p;
    bus.d_req_ready_o = gnt_d;
    bus.csr_rs_o      = '0;
    bus.csr_rd_o      = '0;
    bus.csr_wdata_o   = '0;
    bus.csr_we_o      = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.rsp_src_o     = 1'b0;
    bus.rsp_rdata_o   = '0;
    bus.rsp_err_o     = 1'b0;
    unique case (state_q)
      READ:  bus.csr_rs_o = req_q.addr;
      WRITE: begin
        bus.csr_rd_o    = req_q.addr;
        bus.csr_wdata_o = new_val;
        bus.csr_we_o    = do_write;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_src_o   = req_q.src;
        bus.rsp_rdata_o = old_q;
        bus.rsp_err_o   = ro_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed vector table, arbitration order for both
// FAIR_EN settings, response back-pressure, reset abort and random ops checked
// against a transaction-level model of the CSR file.
module tb_csr_access_ctrl;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  csr_access_ctrl_if bus();
  csr_access_ctrl_if bus0();

  csr_access_ctrl #(.FAIR_EN(1'b1)) u_dut (.clk_i(clk_i), .reset_ni(reset_ni), .bus(bus));
  csr_access_ctrl #(.FAIR_EN(1'b0)) u_dut0 (.clk_i(clk_i), .reset_ni(reset_ni), .bus(bus0));

  logic [31:0] mem [4096];
  assign bus.csr_rdata_i  = mem[bus.csr_rs_o];
  assign bus0.csr_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always @(posedge clk_i) if (bus.csr_we_o) wr_cnt <= wr_cnt + 1;

  typedef struct {
    bit          src;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    bit          exp_we;
    logic [31:0] exp_new;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level rules of the CSR operations.
  function automatic void model(input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [31:0] old,
                                output bit we, output logic [31:0] nv, output bit err);
    bit wr, ro;
    wr  = (op == 2'd1) || (op >= 2'd2 && wdata != 0);
    ro  = (addr >= 12'hC00);
    err = wr && ro;
    we  = wr && !ro;
    case (op)
      2'd1:    nv = wdata;
      2'd2:    nv = old | wdata;
      2'd3:    nv = old & ~wdata;
      default: nv = old;
    endcase
  endfunction

  task automatic set_req(input bit src, input bit v, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] wdata);
    if (src) begin
      bus.d_req_valid_i = v; bus.d_req_op_i = op;
      bus.d_req_addr_i = addr; bus.d_req_wdata_i = wdata;
    end else begin
      bus.p_req_valid_i = v; bus.p_req_op_i = op;
      bus.p_req_addr_i = addr; bus.p_req_wdata_i = wdata;
    end
  endtask

  // One complete transaction with cycle-exact checks; hold = cycles of
  // rsp_ready_i low in RESP, with the other requester knocking meanwhile.
  task automatic do_txn(input bit src, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input bit exp_we,
                        input logic [31:0] exp_new, input bit exp_err,
                        input logic [31:0] exp_old, input int hold);
    bit ok = 0;
    @(negedge clk_i);
    set_req(src, 1'b1, op, addr, wdata);
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((src ? bus.d_req_ready_o : bus.p_req_ready_o) === 1'b1) begin ok = 1; break; end
      @(negedge clk_i); #1;
    end
    chk("accept", {63'd0, ok}, 64'd1);
    if (!ok) begin set_req(src, 1'b0, 2'd0, 12'd0, 32'd0); return; end
    chk("other_ready_low", {63'd0, (src ? bus.p_req_ready_o : bus.d_req_ready_o)}, 64'd0);
    // N+1: READ
    @(negedge clk_i); #1;
    set_req(src, 1'b0, 2'd0, 12'd0, 32'd0);
    chk("read_rs", {52'd0, bus.csr_rs_o}, {52'd0, addr});
    chk("read_we", {63'd0, bus.csr_we_o}, 64'd0);
    // N+2: WRITE
    @(negedge clk_i); #1;
    chk("write_we", {63'd0, bus.csr_we_o}, {63'd0, exp_we});
    chk("write_rsp_early", {63'd0, bus.rsp_valid_o}, 64'd0);
    if (exp_we) begin
      chk("write_rd", {52'd0, bus.csr_rd_o}, {52'd0, addr});
      chk("write_data", {32'd0, bus.csr_wdata_o}, {32'd0, exp_new});
    end
    if (bus.csr_we_o === 1'b1) mem[bus.csr_rd_o] = bus.csr_wdata_o;
    // N+3: RESP
    @(negedge clk_i); #1;
    chk("write_we_drop", {63'd0, bus.csr_we_o}, 64'd0);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp", {29'd0, bus.rsp_valid_o, bus.rsp_src_o, bus.rsp_err_o, bus.rsp_rdata_o},
          {29'd0, 1'b1, src, exp_err, exp_old});
      if (h < hold) begin
        set_req(!src, 1'b1, 2'd0, 12'd0, 32'd0);
        #1;
        chk("hold_ready", {62'd0, bus.p_req_ready_o, bus.d_req_ready_o}, 64'd0);
        @(negedge clk_i); #1;
      end
    end
    set_req(!src, 1'b0, 2'd0, 12'd0, 32'd0);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i); #1;
    bus.rsp_ready_i = 1'b0;
    chk("rsp_done", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("csr_value", {32'd0, mem[addr]}, {32'd0, exp_we ? exp_new : exp_old});
  endtask

  vec_t vecs[9];
  bit   g1[$], g0[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.rsp_ready_i = 1'b0;  bus0.rsp_ready_i = 1'b0;
    set_req(1'b0, 1'b1, 2'd1, 12'h100, 32'h5);
    set_req(1'b1, 1'b1, 2'd1, 12'h100, 32'h5);
    bus0.p_req_valid_i = 1'b1; bus0.p_req_op_i = 2'd0; bus0.p_req_addr_i = 12'd0; bus0.p_req_wdata_i = 32'd0;
    bus0.d_req_valid_i = 1'b1; bus0.d_req_op_i = 2'd0; bus0.d_req_addr_i = 12'd0; bus0.d_req_wdata_i = 32'd0;

    // Reset: all outputs low even with both requesters valid.
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_outs", {bus.p_req_ready_o, bus.d_req_ready_o, bus.rsp_valid_o, bus.rsp_src_o,
                       bus.rsp_err_o, bus.csr_we_o, bus.csr_rs_o, bus.csr_rd_o, bus.rsp_rdata_o[7:0],
                       bus.csr_wdata_o[7:0]}, 64'd0);
    chk("reset_outs0", {62'd0, bus0.p_req_ready_o, bus0.d_req_ready_o}, 64'd0);
    chk("reset_wide", {bus.rsp_rdata_o, bus.csr_wdata_o}, 64'd0);
    bus.p_req_valid_i = 0; bus.d_req_valid_i = 0;
    bus0.p_req_valid_i = 0; bus0.d_req_valid_i = 0;
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Arbitration: both requesters with three READs each, on both DUTs.
    begin
      int pc1 = 3, dc1 = 3, pc0 = 3, dc0 = 3;
      bus.rsp_ready_i = 1'b1; bus0.rsp_ready_i = 1'b1;
      for (int c = 0; c < 100 && (pc1 + dc1 + pc0 + dc0) > 0; c++) begin
        @(negedge clk_i);
        bus.p_req_valid_i  = (pc1 > 0); bus.d_req_valid_i  = (dc1 > 0);
        bus0.p_req_valid_i = (pc0 > 0); bus0.d_req_valid_i = (dc0 > 0);
        #1;
        if (bus.p_req_ready_o && bus.d_req_ready_o) chk("both_ready", 64'd1, 64'd0);
        if (bus.p_req_ready_o)  begin g1.push_back(1'b0); pc1--; end
        if (bus.d_req_ready_o)  begin g1.push_back(1'b1); dc1--; end
        if (bus0.p_req_ready_o) begin g0.push_back(1'b0); pc0--; end
        if (bus0.d_req_ready_o) begin g0.push_back(1'b1); dc0--; end
      end
      chk("arb_timeout", 64'(pc1 + dc1 + pc0 + dc0), 64'd0);
      @(negedge clk_i);
      bus.p_req_valid_i = 0; bus.d_req_valid_i = 0;
      bus0.p_req_valid_i = 0; bus0.d_req_valid_i = 0;
      repeat (5) @(negedge clk_i);
      bus.rsp_ready_i = 1'b0; bus0.rsp_ready_i = 1'b0;
      chk("arb_len", {32'(g1.size()), 32'(g0.size())}, {32'd6, 32'd6});
      for (int i = 0; i < 6 && i < g1.size() && i < g0.size(); i++) begin
        chk($sformatf("fair_grant%0d", i), {63'd0, g1[i]}, {63'd0, i[0]});
        chk($sformatf("fixed_grant%0d", i), {63'd0, g0[i]}, {63'd0, (i >= 3)});
      end
    end

    // Directed vectors.
    vecs[0] = '{0, 2'd2, 12'h300, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 0};
    vecs[1] = '{1, 2'd1, 12'hC00, 32'h0000_1234, 32'hCAFE_0001, 0, 32'h0, 1};
    vecs[2] = '{0, 2'd3, 12'hC80, 32'h0,         32'h0000_0055, 0, 32'h0, 0};
    vecs[3] = '{1, 2'd0, 12'h010, 32'h0000_FFFF, 32'h0000_A5A5, 0, 32'h0, 0};
    vecs[4] = '{0, 2'd3, 12'h020, 32'h0000_000F, 32'h0000_00FF, 1, 32'h0000_00F0, 0};
    vecs[5] = '{1, 2'd1, 12'h7FF, 32'hDEAD_BEEF, 32'h0000_0001, 1, 32'hDEAD_BEEF, 0};
    vecs[6] = '{0, 2'd2, 12'hFFF, 32'h0000_0001, 32'h0,         0, 32'h0, 1};
    vecs[7] = '{1, 2'd2, 12'h040, 32'h0,         32'h0000_0033, 0, 32'h0, 0};
    vecs[8] = '{0, 2'd3, 12'hBFF, 32'hFFFF_FFFF, 32'h0000_1234, 1, 32'h0, 0};
    for (int i = 0; i < 9; i++) begin
      mem[vecs[i].addr] = vecs[i].init;
      do_txn(vecs[i].src, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_we,
             vecs[i].exp_new, vecs[i].exp_err, vecs[i].init, 0);
    end

    // Back-pressure: five cycles of rsp_ready_i low.
    mem[12'h123] = 32'h0F0F_0000;
    do_txn(1'b0, 2'd2, 12'h123, 32'h0000_00F0, 1'b1, 32'h0F0F_00F0, 1'b0, 32'h0F0F_0000, 5);

    // Random ops against the model.
    for (int n = 0; n < 40; n++) begin
      bit src, we, err;
      logic [1:0] op;
      logic [11:0] addr;
      logic [31:0] wdata, old, nv;
      src   = 1'($urandom);
      op    = 2'($urandom);
      addr  = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 1) == 1) mem[addr] = $urandom;
      old = mem[addr];
      model(op, addr, wdata, old, we, nv, err);
      do_txn(src, op, addr, wdata, we, nv, err, old, int'($urandom_range(0, 2)));
    end

    // Reset during WRITE aborts the op with no write and no response.
    begin
      int wc;
      bit ok = 0;
      mem[12'h100] = 32'h0000_0011;
      @(negedge clk_i);
      set_req(1'b0, 1'b1, 2'd1, 12'h100, 32'h0000_0099);
      #1;
      for (int i = 0; i < 20; i++) begin
        if (bus.p_req_ready_o === 1'b1) begin ok = 1; break; end
        @(negedge clk_i); #1;
      end
      chk("rst_accept", {63'd0, ok}, 64'd1);
      @(negedge clk_i); #1;
      set_req(1'b0, 1'b0, 2'd0, 12'd0, 32'd0);
      @(negedge clk_i); #1;
      chk("rst_in_write", {63'd0, bus.csr_we_o}, 64'd1);
      wc = wr_cnt;
      reset_ni = 1'b0;
      #1;
      chk("rst_we_drop", {62'd0, bus.csr_we_o, bus.rsp_valid_o}, 64'd0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_i); #1;
        chk("rst_no_rsp", {62'd0, bus.rsp_valid_o, bus.csr_we_o}, 64'd0);
      end
      chk("rst_no_write", 64'(wr_cnt), 64'(wc));
      do_txn(1'b1, 2'd2, 12'h100, 32'h0000_0100, 1'b1, 32'h0000_0111, 1'b0, 32'h0000_0011, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter FAIR_EN, default 1: 1 enables alternating grant under contention; 0 gives the pipeline fixed priority.
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  rising-edge clock.
REQ-003 reset_ni  in  1  asynchronous active-low reset.
REQ-004 p_req_valid_i  in  1  pipeline request valid; p_req_ready_o  out  1  pipeline request accepted.
REQ-005 p_req_op_i  in  2  pipeline op: 00 READ, 01 RW, 10 RS, 11 RC; p_req_addr_i  in  12  CSR address; p_req_wdata_i  in  32  operand.
REQ-006 d_req_valid_i, d_req_ready_o, d_req_op_i, d_req_addr_i, d_req_wdata_i: debug requester, same widths and meaning as the p_ ports.
REQ-007 rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_src_o  out  1 (0 pipeline, 1 debug); rsp_rdata_o  out  32 (old CSR value); rsp_err_o  out  1.
REQ-008 csr_rs_o  out  12  CSR read address; csr_rdata_i  in  32  CSR read data (combinational from csr_rs_o).
REQ-009 csr_rd_o  out  12  CSR write address; csr_wdata_o  out  32  write data; csr_we_o  out  1  write enable.

Function
REQ-010 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-011 Transitions SHALL be: IDLE->READ on accept; READ->WRITE always; WRITE->RESP always; RESP->IDLE on rsp_valid_o & rsp_ready_i; otherwise hold.
REQ-012 Ready SHALL be asserted only in IDLE, to at most one requester per cycle, and only to a requester whose valid is high; accept = valid & ready.
REQ-013 Arbitration: single valid gets the grant; both valid with FAIR_EN=0 grants the pipeline; both valid with FAIR_EN=1 grants the requester not granted last (last_grant resets to debug, so the pipeline wins first).
REQ-014 On accept, SHALL latch op, addr, wdata and source.
REQ-015 READ: csr_rs_o = latched addr; SHALL capture csr_rdata_i into old_q.
REQ-016 WRITE: csr_rd_o = latched addr and csr_wdata_o = new value; csr_we_o=1 exactly one cycle unless suppressed (REQ-018/019).
REQ-017 New value: RW = wdata; RS = old_q | wdata; RC = old_q & ~wdata; 32-bit bitwise, no carries.
REQ-018 Write SHALL be suppressed for op READ, and for RS/RC when wdata == 0; no error in either case.
REQ-019 addr[11:10] == 2'b11 (read-only) with op RW, or RS/RC with nonzero wdata: write suppressed, rsp_err_o=1.
REQ-020 RESP: rsp_valid_o=1, rsp_rdata_o=old_q, rsp_src_o=latched source, rsp_err_o per REQ-019; all SHALL hold stable until the handshake.
REQ-021 Latency: accept at cycle N, write at N+2, rsp_valid_o first high at N+3; fixed regardless of suppression.
REQ-022 Throughput: the next accept SHALL occur no earlier than the cycle after the RESP handshake (max one op per 4 cycles).
REQ-023 Outside READ, csr_rs_o=0; outside WRITE, csr_rd_o=0 and csr_wdata_o=0; csr_we_o=0 whenever suppressed or not in WRITE.
REQ-024 Requests arriving while not IDLE SHALL wait (ready=0); no request is dropped or reordered within a requester.

Reset
REQ-025 reset_ni low SHALL immediately force state=IDLE, last_grant=debug, and old_q and all latches to 0.
REQ-026 While reset_ni is low, all outputs SHALL be 0, including csr_we_o and rsp_valid_o.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no write and no response; the first accept after reset release is a fresh transaction.

Verification
REQ-028 Pipeline RS addr 0x300, wdata 0x0000_00F0, CSR holds 0x0000_000F -> write 0x0000_00FF at N+2; rsp rdata 0x0000_000F, err 0, src 0 at N+3.
REQ-029 Both valid, FAIR_EN=1, three back-to-back ops each -> grant order P,D,P,D,P,D; FAIR_EN=0 -> all P first.
REQ-030 Debug RW addr 0xC00 (read-only) wdata 0x1234 -> csr_we_o never high; rsp err 1, rdata = CSR value, src 1.
REQ-031 RC wdata 0 on addr 0xC80 -> no write, err 0; READ op -> no write, err 0.
REQ-032 rsp_ready_i held low 5 cycles in RESP -> outputs stable, both req_ready 0; handshake -> IDLE next cycle.
REQ-033 reset_ni pulsed low during WRITE -> csr_we_o drops to 0 immediately, no response; a new request after release completes normally.
